// File: rtl/router_port_rx.sv
// Drains one router output channel: reframes the FIFO byte stream into
// header/payload/parity packets, checks them and keeps saturating counters.
module router_port_rx #(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int         GAP_MAX = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  output logic        read_enb,
  output logic [7:0]  pkt_byte,
  output logic        pkt_byte_vld,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic        pkt_done,
  output logic        parity_err,
  output logic        addr_err,
  output logic        trunc_err,
  output logic [5:0]  pkt_len,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DONE} state_e;

  localparam logic [7:0] GAP_LIM = 8'(GAP_MAX - 1);

  state_e      r_state, w_next;
  logic        r_rd_pend;
  logic [6:0]  r_reads_left;
  logic [6:0]  r_rcvd;
  logic [7:0]  r_par_acc;
  logic [7:0]  r_gap_cnt;
  logic [5:0]  r_len;
  logic        r_perr, r_aerr, r_terr;
  logic [7:0]  r_byte;
  logic        r_bvld, r_sop, r_eop;
  logic [15:0] r_pkt_cnt, r_err_cnt;

  logic        w_rd_allow;
  logic        w_gap_idle;
  logic        w_abort;
  logic        w_last;
  logic        w_any_err;

  // A stalled body cycle: more reads owed but the channel is empty.
  assign w_gap_idle = (r_state == S_BODY) && (r_reads_left != 7'd0) && !vld_out;
  assign w_abort    = w_gap_idle && (r_gap_cnt == GAP_LIM);
  assign w_last     = (r_state == S_BODY) && r_rd_pend && (r_rcvd == {1'b0, r_len});
  assign w_any_err  = r_perr | r_aerr | r_terr;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (read_enb) w_next = S_HDR;
      S_HDR:  w_next = S_BODY;
      S_BODY: if (w_last || w_abort) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_rd_allow = 1'b0;
    pkt_done   = 1'b0;
    case (r_state)
      S_IDLE: w_rd_allow = 1'b1;
      S_BODY: w_rd_allow = (r_reads_left != 7'd0);
      S_DONE: pkt_done   = 1'b1;
      default: ;
    endcase
  end

  // Gated by resetn so the strobe is quiet while reset holds the block in IDLE.
  assign read_enb = vld_out & w_rd_allow & resetn;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_rd_pend <= 1'b0;
    else         r_rd_pend <= read_enb;
  end

  // Packet framing and checking
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_reads_left <= '0;
      r_rcvd       <= '0;
      r_par_acc    <= '0;
      r_gap_cnt    <= '0;
      r_len        <= '0;
      r_perr       <= 1'b0;
      r_aerr       <= 1'b0;
      r_terr       <= 1'b0;
    end else begin
      case (r_state)
        S_HDR: begin
          r_len        <= data_out[7:2];
          r_aerr       <= (data_out[1:0] != PORT_ID);
          r_perr       <= 1'b0;
          r_terr       <= 1'b0;
          r_par_acc    <= data_out;
          r_reads_left <= {1'b0, data_out[7:2]} + 7'd1;
          r_rcvd       <= '0;
          r_gap_cnt    <= '0;
        end
        S_BODY: begin
          if (read_enb)        r_reads_left <= r_reads_left - 7'd1;
          if (read_enb)        r_gap_cnt    <= '0;
          else if (w_gap_idle) r_gap_cnt    <= r_gap_cnt + 8'd1;
          if (r_rd_pend) begin
            r_rcvd <= r_rcvd + 7'd1;
            if (w_last) r_perr    <= (data_out != r_par_acc);
            else        r_par_acc <= r_par_acc ^ data_out;
          end
          if (w_abort) begin
            r_terr <= 1'b1;
            r_perr <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Forwarded byte stream, one cycle behind the capture
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_byte <= '0;
      r_bvld <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
    end else begin
      r_bvld <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      if (r_state == S_HDR) begin
        r_byte <= data_out;
        r_bvld <= 1'b1;
        r_sop  <= 1'b1;
      end else if (r_state == S_BODY && r_rd_pend) begin
        r_byte <= data_out;
        r_bvld <= 1'b1;
        r_eop  <= w_last;
      end
    end
  end

  // Saturating statistics, updated as the packet retires
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else if (r_state == S_DONE) begin
      if (!r_terr && r_pkt_cnt != 16'hFFFF)   r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_any_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign pkt_byte     = r_byte;
  assign pkt_byte_vld = r_bvld;
  assign pkt_sop      = r_sop;
  assign pkt_eop      = r_eop;
  assign parity_err   = r_perr;
  assign addr_err     = r_aerr;
  assign trunc_err    = r_terr;
  assign pkt_len      = r_len;
  assign pkt_cnt      = r_pkt_cnt;
  assign err_cnt      = r_err_cnt;

endmodule
